// File: rtl/regbank_seq_ctrl_pkg.sv
// Shared types for the register-bank sequencer: FSM encoding, ALU opcodes, bank geometry.
// Imported by the sequencer, its operand mux and the ALU.
package regbank_seq_ctrl_pkg;

    localparam int REG_AW = 3;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } seq_state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
        return {{(DATA_W-8){v[7]}}, v};
    endfunction

endpackage

// File: rtl/regseq_opnd_mux.sv
// Operand-B select: sign-extended 8-bit immediate or bank read port 2.
// Combinational, zero latency; no backpressure.
module regseq_opnd_mux
    import regbank_seq_ctrl_pkg::*;
(
    input  logic              i_use_imm,
    input  logic [7:0]        i_imm,
    input  logic [DATA_W-1:0] i_rd_data2,
    output logic [DATA_W-1:0] o_opnd_b
);

    assign o_opnd_b = i_use_imm ? sext8(i_imm) : i_rd_data2;

endmodule

// File: rtl/regbank_seq_ctrl.sv
// Sequences one reg-reg op: accept, bank read, external ALU, writeback. Optional REGSEQ_R0_PROTECT_EN blocks writes to r0.
// Latency: writeback in the 3rd cycle after acceptance with a single-cycle ALU; best case 1 instr / 4 cycles.
// Backpressure: instr_ready only in IDLE, so offered instructions stall until the current one retires or times out.
module regbank_seq_ctrl
    import regbank_seq_ctrl_pkg::*;
#(
    parameter int ALU_TMO = 15,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [2:0]        instr_rs1,
    input  logic [2:0]        instr_rs2,
    input  logic [2:0]        instr_rd,
    input  logic              instr_use_imm,
    input  logic [7:0]        instr_imm,
    output logic [2:0]        read_reg1,
    output logic [2:0]        read_reg2,
    input  logic [31:0]       read_data1,
    input  logic [31:0]       read_data2,
    output logic [2:0]        write_reg,
    output logic [31:0]       write_data,
    output logic              write_en,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [31:0]       alu_result,
    output logic              done,
    output logic              err_tmo,
    output logic [CNT_W-1:0]  retired
`ifdef REGSEQ_R0_PROTECT_EN
    ,
    output logic              r0_wr_blocked
`endif
);

    localparam int TW = (ALU_TMO > 1) ? $clog2(ALU_TMO) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(ALU_TMO - 1);

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic [2:0]        r_op, r_rs1, r_rs2, r_rd;
    logic              r_use_imm;
    logic [7:0]        r_imm;
    logic [TW-1:0]     r_cnt;
    logic [31:0]       r_alu_a, r_alu_b, r_wdata;
    logic              r_err;
    logic [CNT_W-1:0]  r_retired;
    logic [31:0]       w_opnd_b;
    logic              w_accept, w_exec_ok, w_tmo, w_wr_allow;

    regseq_opnd_mux u_opnd_mux (
        .i_use_imm  (r_use_imm),
        .i_imm      (r_imm),
        .i_rd_data2 (read_data2),
        .o_opnd_b   (w_opnd_b)
    );

    assign w_accept  = (r_state == ST_IDLE) && instr_valid;
    assign w_exec_ok = (r_state == ST_EXEC) && alu_done;
    // alu_done wins over the timeout in the final allowed EXEC cycle
    assign w_tmo     = (r_state == ST_EXEC) && !alu_done && (r_cnt == TMO_LAST);

`ifdef REGSEQ_R0_PROTECT_EN
    assign w_wr_allow = (r_rd != 3'd0);
`else
    assign w_wr_allow = 1'b1;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_READ;
            ST_READ: w_next = ST_EXEC;
            ST_EXEC: begin
                if (w_exec_ok)  w_next = ST_WB;
                else if (w_tmo) w_next = ST_IDLE;
            end
            ST_WB:   w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_use_imm <= 1'b0;
            r_imm     <= '0;
            r_cnt     <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_retired <= '0;
        end else begin
            if (w_accept) begin
                r_op      <= instr_op;
                r_rs1     <= instr_rs1;
                r_rs2     <= instr_rs2;
                r_rd      <= instr_rd;
                r_use_imm <= instr_use_imm;
                r_imm     <= instr_imm;
            end
            // read data from the READ-cycle negedge is valid at this edge
            if (r_state == ST_READ) begin
                r_alu_a <= read_data1;
                r_alu_b <= w_opnd_b;
                r_cnt   <= '0;
            end else if (r_state == ST_EXEC) begin
                r_cnt   <= r_cnt + TW'(1);
            end
            if (w_exec_ok)          r_wdata   <= alu_result;
            if (w_tmo)              r_err     <= 1'b1;
            if (r_state == ST_WB)   r_retired <= r_retired + CNT_W'(1);
        end
    end

`ifdef REGSEQ_R0_PROTECT_EN
    logic r_r0_blk;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                   r_r0_blk <= 1'b0;
        else if (r_state == ST_WB && !w_wr_allow)   r_r0_blk <= 1'b1;
    end
    assign r0_wr_blocked = r_r0_blk;
`endif

    assign instr_ready = (r_state == ST_IDLE) && rst;
    assign read_reg1   = r_rs1;
    assign read_reg2   = r_rs2;
    assign write_reg   = r_rd;
    assign write_data  = r_wdata;
    assign done        = (r_state == ST_WB);
    assign write_en    = (r_state == ST_WB) && w_wr_allow;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_op;
    assign alu_start   = (r_state == ST_EXEC) && (r_cnt == '0);
    assign err_tmo     = r_err;
    assign retired     = r_retired;

endmodule

// File: doc/regbank_seq_ctrl.md
Name: regbank_seq_ctrl

Overview:
- Sequences one register-to-register operation at a time through the 8x32 register bank and an external ALU.
- Flow: accept instruction, read operands, run ALU, write back result.
- The bank samples its read addresses on the clock negedge and updates registered read data. This block therefore allows one full cycle between driving the addresses and sampling the data.
- Sits between the instruction source and the bank/ALU pair. It is the bank's only write master.

Parameters:
- ALU_TMO, default 15: maximum EXEC cycles to wait for alu_done before aborting.
- CNT_W, default 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  block can accept (high only in IDLE).
- instr_op  in  3  ALU opcode, passed through to alu_op.
- instr_rs1  in  3  source register 1.
- instr_rs2  in  3  source register 2.
- instr_rd  in  3  destination register.
- instr_use_imm  in  1  when 1, operand B = sign-extended instr_imm.
- instr_imm  in  8  immediate value.
- read_reg1  out  3  bank read address 1.
- read_reg2  out  3  bank read address 2.
- read_data1  in  32  bank read data 1.
- read_data2  in  32  bank read data 2.
- write_reg  out  3  bank write address.
- write_data  out  32  bank write data.
- write_en  out  1  bank write strobe.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_op  out  3  ALU opcode.
- alu_start  out  1  one-cycle ALU start pulse.
- alu_done  in  1  ALU result valid.
- alu_result  in  32  ALU result.
- done  out  1  one-cycle pulse on writeback.
- err_tmo  out  1  sticky ALU timeout flag.
- retired  out  CNT_W  count of completed writebacks.

Behaviour:
- Reset (rst=0, asynchronous): all outputs are zero, FSM=IDLE, counters cleared. This includes write_en=0, alu_start=0, done=0, err_tmo=0, retired=0 and instr_ready=0 while reset is held.
- Reset asserted mid-operation: the operation is abandoned and no bank write occurs.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid, latch op/rs1/rs2/rd/use_imm/imm and go to READ.
- READ:
  - read_reg1/2 are driven from the latched rs1/rs2. The address outputs hold these values from READ through WB.
  - Go to EXEC unconditionally. The bank captures on the READ-cycle negedge, so read_data is valid at the next posedge.
- EXEC, first cycle:
  - Register alu_a=read_data1.
  - Register alu_b = use_imm ? {{24{imm[7]}},imm} : read_data2.
  - alu_op=op. alu_start is high for this cycle only.
- EXEC, waiting:
  - The cycle counter increments each EXEC cycle.
  - On alu_done=1 (valid in any EXEC cycle, including the first), latch alu_result into write_data and go to WB.
  - If the counter reaches ALU_TMO without alu_done: set err_tmo, go to IDLE, no write.
- WB:
  - write_en=1, write_reg=rd, done=1 for exactly one cycle.
  - retired increments and wraps at 2^CNT_W. Go to IDLE.
- Latency: accept at edge N; minimum (single-cycle ALU) done/write_en high in cycle N+3. Throughput is one instruction per 4 cycles at best.
- instr_ready drops in the cycle after acceptance. Back-to-back instr_valid is stalled, not lost.
- rd equal to rs1 or rs2 is legal; operands were captured before the write.
- err_tmo clears only on reset.
- alu_done outside EXEC is ignored.

Optional Feature:
- Macro: REGSEQ_R0_PROTECT_EN.
- Defined: an instruction with rd=0 runs READ/EXEC normally but WB suppresses write_en. done still pulses, retired still increments, and a sticky r0_wr_blocked output is set (port exists only under the macro).
- Undefined: rd=0 is written like any other register.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, READ=1, EXEC=2, WB=3).
  - ALU opcode constants, shared with the ALU.
  - REG_AW=3 and DATA_W=32.
- One natural sub-module, regseq_opnd_mux: immediate sign-extension plus operand-B select. Everything else stays flat.

Test Plan:
- Bank at reset values (regs[i]=i); op=ADD, rs1=2, rs2=3, rd=4, ALU done in 1 cycle -> write_en with write_reg=4, write_data=5 exactly 3 cycles after acceptance; done=1; retired=1.
- use_imm=1, imm=8'hFF, rs1=5, op=ADD -> alu_b=32'hFFFFFFFF, write_data=4.
- alu_done delayed 6 cycles -> FSM stays in EXEC; writeback 8 cycles after acceptance; alu_start pulses once.
- alu_done never asserted -> after 15 EXEC cycles err_tmo=1, no write_en, instr_ready=1 next cycle.
- rst driven low during EXEC -> write_en never asserts; all outputs 0; after release the next instruction completes normally.
- With REGSEQ_R0_PROTECT_EN defined, rd=0 -> done=1, write_en stays 0, r0_wr_blocked=1. Without the macro, the write to register 0 occurs.
